// File: rtl/seq_det_pkg.sv
// Shared types and default constants for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    FILL,
    HUNT
  } state_e;

  localparam int unsigned    DEF_PATTERN_W = 3;
  localparam logic [2:0]     DEF_PATTERN   = 3'b110;
  localparam int unsigned    DEF_CNT_W     = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky all-ones flag and synchronous clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
      // ~1 is all-ones minus one: this increment lands on the ceiling
      if (count == ~W'(1)) begin
        sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector with registered match pulse.
// Define SEQ_DET_COUNT_EN to add the saturating match counter (match_cnt, cnt_sat).
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned          PATTERN_W = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(DEF_PATTERN),
  parameter int unsigned          OVERLAP   = 1,
  parameter int unsigned          CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clear,
`ifdef SEQ_DET_COUNT_EN
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
`endif
  output logic             match
);

  localparam int unsigned FillW = $clog2(PATTERN_W + 1);

  if (PATTERN_W < 2 || PATTERN_W > 16 || CNT_W < 1) begin : g_param_err
    $error("seq_detector: illegal parameter value");
  end

  // Reset release is pipelined through two flops before bits are accepted
  logic [1:0] rst_sync_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  state_e               state_q;
  logic [PATTERN_W-1:0] hist_q;
  logic [PATTERN_W-1:0] hist_shift;
  logic [FillW-1:0]     fill_q;
  logic                 accept;
  logic                 window_full;
  logic                 hit;
  logic                 unused_hist_msb;

  assign accept          = bit_valid & rst_sync_q[1] & ~clear;
  assign hist_shift      = {hist_q[PATTERN_W-2:0], bit_in};
  // Counts the bit being sampled now, so FILL on its last bit already qualifies
  assign window_full     = (state_q == HUNT) || (fill_q == FillW'(PATTERN_W - 1));
  assign hit             = accept && window_full && (hist_shift == PATTERN);
  assign unused_hist_msb = hist_q[PATTERN_W-1];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      match   <= 1'b0;
    end else begin
      match <= hit;
      if (clear) begin
        state_q <= FILL;
        hist_q  <= '0;
        fill_q  <= '0;
      end else if (accept) begin
        hist_q <= hist_shift;
        if (hit && OVERLAP == 0) begin
          state_q <= FILL;
          fill_q  <= '0;
        end else if (state_q == FILL) begin
          fill_q <= fill_q + 1'b1;
          if (window_full) begin
            state_q <= HUNT;
          end
        end
      end
    end
  end

  a_no_double_match: assert property (@(posedge clk) disable iff (!arst_n)
    (OVERLAP == 0 && match) |=> !match);

`ifdef SEQ_DET_COUNT_EN
  sat_counter #(
    .W (CNT_W)
  ) u_sat_counter (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (hit),
    .clr    (clear),
    .count  (match_cnt),
    .sat    (cnt_sat)
  );

  a_cnt_monotonic: assert property (@(posedge clk) disable iff (!arst_n)
    !clear |=> match_cnt >= $past(match_cnt));
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench: shared stimulus into four parameterisations of seq_detector.
module tb_seq_detector;

  logic clk;
  logic arst_n;
  logic bit_valid;
  logic bit_in;
  logic clear;
  logic m_def, m_o, m_n, m_c2;

`ifdef SEQ_DET_COUNT_EN
  logic [7:0] cnt_def, cnt_o, cnt_n;
  logic [1:0] cnt_c2;
  logic       sat_def, sat_o, sat_n, sat_c2;
`endif

  int checks = 0;
  int errors = 0;

  seq_detector u_def (
    .clk       (clk),
    .arst_n    (arst_n),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .clear     (clear),
`ifdef SEQ_DET_COUNT_EN
    .match_cnt (cnt_def),
    .cnt_sat   (sat_def),
`endif
    .match     (m_def)
  );

  seq_detector #(
    .PATTERN (3'b101),
    .OVERLAP (1)
  ) u_p101_ov (
    .clk       (clk),
    .arst_n    (arst_n),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .clear     (clear),
`ifdef SEQ_DET_COUNT_EN
    .match_cnt (cnt_o),
    .cnt_sat   (sat_o),
`endif
    .match     (m_o)
  );

  seq_detector #(
    .PATTERN (3'b101),
    .OVERLAP (0)
  ) u_p101_nov (
    .clk       (clk),
    .arst_n    (arst_n),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .clear     (clear),
`ifdef SEQ_DET_COUNT_EN
    .match_cnt (cnt_n),
    .cnt_sat   (sat_n),
`endif
    .match     (m_n)
  );

  seq_detector #(
    .CNT_W (2)
  ) u_cnt2 (
    .clk       (clk),
    .arst_n    (arst_n),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .clear     (clear),
`ifdef SEQ_DET_COUNT_EN
    .match_cnt (cnt_c2),
    .cnt_sat   (sat_c2),
`endif
    .match     (m_c2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // One cycle of stimulus; expected matches are those visible after its posedge
  typedef struct packed {
    logic v;
    logic b;
    logic c;
    logic e_def;
    logic e_o;
    logic e_n;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic b, input logic c,
                     input logic ed, input logic eo, input logic en);
    vec_t t;
    t.v = v; t.b = b; t.c = c; t.e_def = ed; t.e_o = eo; t.e_n = en;
    vecs.push_back(t);
  endtask

  task automatic add_gap_bit(input logic b, input logic ed, input logic eo, input logic en);
    add(1'b1, b, 1'b0, ed, eo, en);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    clear     = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    @(negedge clk);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    arst_n    = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    clear     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset match def", {31'b0, m_def}, 32'd0);
    chk("reset match p101", {30'b0, m_o, m_n}, 32'd0);
`ifdef SEQ_DET_COUNT_EN
    chk("reset cnt def", {24'b0, cnt_def}, 32'd0);
    chk("reset sat c2", {31'b0, sat_c2}, 32'd0);
`endif
    arst_n = 1'b1;
    idle(3);

    // 1,1,0 back to back
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // 1,1,0,1,1,0 with two idle cycles between bits
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_gap_bit(1'b1, 1'b0, 1'b0, 1'b0);
    add_gap_bit(1'b1, 1'b0, 1'b0, 1'b0);
    add_gap_bit(1'b0, 1'b1, 1'b0, 1'b0);
    add_gap_bit(1'b1, 1'b0, 1'b1, 1'b1);
    add_gap_bit(1'b1, 1'b0, 1'b0, 1'b0);
    add_gap_bit(1'b0, 1'b1, 1'b0, 1'b0);
    // 1,0,1,0,1: overlapping vs non-overlapping 101
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // clear together with the completing 0 wins; the next 0 starts a fresh fill
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      bit_valid = vecs[i].v;
      bit_in    = vecs[i].b;
      clear     = vecs[i].c;
      @(negedge clk);
      chk($sformatf("vec%0d def", i), {31'b0, m_def}, {31'b0, vecs[i].e_def});
      chk($sformatf("vec%0d p101 ov", i), {31'b0, m_o}, {31'b0, vecs[i].e_o});
      chk($sformatf("vec%0d p101 nov", i), {31'b0, m_n}, {31'b0, vecs[i].e_n});
    end
    idle(1);

    // Reset mid-pattern discards the 1,1 already held
    do_clear();
    send(1'b1);
    send(1'b1);
    arst_n = 1'b0;
    @(negedge clk);
    chk("in reset match", {31'b0, m_def}, 32'd0);
    arst_n = 1'b1;
    idle(3);
    send(1'b0);
    chk("post reset 0 no match", {31'b0, m_def}, 32'd0);
    send(1'b1);
    send(1'b1);
    send(1'b0);
    chk("post reset 110 match", {31'b0, m_def}, 32'd1);
`ifdef SEQ_DET_COUNT_EN
    chk("post reset cnt", {24'b0, cnt_def}, 32'd1);
`endif
    // Async assertion clears the live pulse without waiting for a clock
    arst_n = 1'b0;
    #1;
    chk("async reset match", {31'b0, m_def}, 32'd0);
`ifdef SEQ_DET_COUNT_EN
    chk("async reset cnt", {24'b0, cnt_def}, 32'd0);
`endif
    @(negedge clk);
    arst_n = 1'b1;
    idle(3);

    // Four matches into a 2-bit counter, then clear
    do_clear();
    for (int k = 1; k <= 4; k++) begin
      send(1'b1);
      send(1'b1);
      send(1'b0);
      chk($sformatf("cnt seq %0d match c2", k), {31'b0, m_c2}, 32'd1);
`ifdef SEQ_DET_COUNT_EN
      chk($sformatf("cnt seq %0d cnt c2", k), {30'b0, cnt_c2}, (k < 3) ? k : 3);
      chk($sformatf("cnt seq %0d sat c2", k), {31'b0, sat_c2}, (k >= 3) ? 1 : 0);
      chk($sformatf("cnt seq %0d cnt def", k), {24'b0, cnt_def}, k);
`endif
    end
    do_clear();
    chk("after clear match c2", {31'b0, m_c2}, 32'd0);
`ifdef SEQ_DET_COUNT_EN
    chk("after clear cnt c2", {30'b0, cnt_c2}, 32'd0);
    chk("after clear sat c2", {31'b0, sat_c2}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
